// File: rtl/ysyx_25020042_fetch_pc.sv
// Fetch PC unit: owns the architectural fetch PC, issues one outstanding
// instruction fetch at a time, and buffers the returned instruction in a
// single-entry output register until the decoder consumes it. Trap and
// branch/jump redirects retarget the PC and squash any fetch still in flight.
module ysyx_25020042_fetch_pc #(
  parameter int                PC_LEN    = 32,
  parameter int                INST_LEN  = 32,
  parameter int                INS_BYTES = 4,
  parameter logic [PC_LEN-1:0] RESET_VEC = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trap_valid,
  input  logic [PC_LEN-1:0]   trap_pc,
  input  logic                redir_valid,
  input  logic [PC_LEN-1:0]   redir_pc,
  output logic                req_valid,
  output logic [PC_LEN-1:0]   req_addr,
  input  logic                req_ready,
  input  logic                rsp_valid,
  input  logic [INST_LEN-1:0] rsp_data,
  output logic                inst_valid,
  output logic [INST_LEN-1:0] inst,
  output logic [PC_LEN-1:0]   inst_pc,
  input  logic                inst_ready
);

  typedef enum logic [1:0] {
    S_IDLE,   // single settling cycle after reset
    S_ISSUE,  // request presented at pc
    S_WAIT,   // request accepted, waiting for the response
    S_HOLD    // output buffer full, waiting for the decoder
  } state_t;

  state_t              state_q, state_d;
  logic [PC_LEN-1:0]   pc_q, pc_d;
  logic                squash_q, squash_d;
  logic                inst_valid_q, inst_valid_d;
  logic [INST_LEN-1:0] inst_q, inst_d;
  logic [PC_LEN-1:0]   inst_pc_q, inst_pc_d;

  // Trap outranks branch/jump; either one is a redirect.
  logic              redirect;
  logic [PC_LEN-1:0] target;

  assign redirect = trap_valid | redir_valid;
  assign target   = trap_valid ? trap_pc : redir_pc;

  // State register with synchronous reset; reset wins over every other input.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VEC;
      squash_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      squash_q     <= squash_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // Next-state logic: sequencing of request, response and buffer drain,
  // with redirects always taking precedence over the sequential PC.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    squash_d     = squash_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_ISSUE;
        if (redirect) pc_d = target;
      end

      S_ISSUE: begin
        if (redirect) pc_d = target;
        // Without a handshake a redirect simply retracts the request and the
        // next cycle presents the new target. With a handshake the request
        // already left, so its response must be discarded.
        if (req_ready) begin
          state_d  = S_WAIT;
          squash_d = redirect;
        end
      end

      S_WAIT: begin
        if (redirect) pc_d = target;
        if (rsp_valid) begin
          state_d = S_ISSUE;
          if (squash_q || redirect) begin
            squash_d = 1'b0;
          end else begin
            inst_d       = rsp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + PC_LEN'(INS_BYTES);
            state_d      = S_HOLD;
          end
        end else if (redirect) begin
          squash_d = 1'b1;
        end
      end

      S_HOLD: begin
        // A redirect flushes the buffer; a simultaneous inst_ready is
        // treated as a completed consume, so both exits look identical.
        if (redirect || inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = S_ISSUE;
        end
        if (redirect) pc_d = target;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign req_valid  = (state_q == S_ISSUE);
  assign req_addr   = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_ysyx_25020042_fetch_pc.sv
// Bench for the fetch PC unit: directed vector table, hand-written reset and
// wrap sequences, and randomized stimulus scored against a transaction-level
// model of the fetch loop.
module tb_ysyx_25020042_fetch_pc;

  localparam logic [31:0] RV_A = 32'h8000_0000;
  localparam logic [31:0] RV_B = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, trap_valid, redir_valid, req_ready, rsp_valid, inst_ready;
  logic [31:0] trap_pc, redir_pc, rsp_data;

  logic        a_req_valid, a_inst_valid, b_req_valid, b_inst_valid;
  logic [31:0] a_req_addr, a_inst, a_inst_pc, b_req_addr, b_inst, b_inst_pc;

  ysyx_25020042_fetch_pc dut_a (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .req_valid(a_req_valid), .req_addr(a_req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(a_inst_valid), .inst(a_inst), .inst_pc(a_inst_pc),
    .inst_ready(inst_ready)
  );

  ysyx_25020042_fetch_pc #(.RESET_VEC(RV_B)) dut_b (
    .clk(clk), .rst(rst),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(b_inst_valid), .inst(b_inst), .inst_pc(b_inst_pc),
    .inst_ready(inst_ready)
  );

  typedef struct packed {
    logic        rst;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        inst_ready;
  } stim_t;

  typedef struct packed {
    logic        req_valid;
    logic [31:0] req_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
  } obs_t;

  typedef struct packed {
    stim_t s;
    obs_t  e;
  } vec_t;

  // Transaction view of the unit: has it started fetching, is a request
  // outstanding, is its answer doomed, and what sits in the output buffer.
  typedef struct packed {
    logic        started;
    logic        outstanding;
    logic        doomed;
    logic        held;
    logic [31:0] pc;
    logic [31:0] held_inst;
    logic [31:0] held_pc;
  } model_t;

  int     errors = 0;
  int     checks = 0;
  model_t ma, mb;
  vec_t   vecs[$];

  function automatic model_t m_step(model_t m, stim_t s, logic [31:0] rv);
    model_t      n;
    logic        redirect;
    logic [31:0] target;
    n        = m;
    redirect = s.trap_valid | s.redir_valid;
    target   = s.trap_valid ? s.trap_pc : s.redir_pc;
    if (s.rst) begin
      n    = '0;
      n.pc = rv;
      return n;
    end
    if (!m.started) begin
      n.started = 1'b1;
    end else if (m.outstanding) begin
      if (s.rsp_valid) begin
        n.outstanding = 1'b0;
        n.doomed      = 1'b0;
        if (!m.doomed && !redirect) begin
          n.held      = 1'b1;
          n.held_inst = s.rsp_data;
          n.held_pc   = m.pc;
          n.pc        = m.pc + 32'd4;
        end
      end else if (redirect) begin
        n.doomed = 1'b1;
      end
    end else if (m.held) begin
      if (redirect || s.inst_ready) n.held = 1'b0;
    end else if (s.req_ready) begin
      n.outstanding = 1'b1;
      n.doomed      = redirect;
    end
    if (redirect) n.pc = target;
    return n;
  endfunction

  function automatic obs_t m_obs(model_t m);
    obs_t o;
    o.req_valid  = m.started && !m.outstanding && !m.held;
    o.req_addr   = m.pc;
    o.inst_valid = m.held;
    o.inst       = m.held_inst;
    o.inst_pc    = m.held_pc;
    return o;
  endfunction

  function automatic stim_t mk(logic r, logic tv, logic [31:0] tpc, logic rv,
                               logic [31:0] rpc, logic rr, logic rs,
                               logic [31:0] rd, logic ir);
    stim_t s;
    s = '{rst: r, trap_valid: tv, trap_pc: tpc, redir_valid: rv, redir_pc: rpc,
          req_ready: rr, rsp_valid: rs, rsp_data: rd, inst_ready: ir};
    return s;
  endfunction

  function automatic obs_t ob(logic v, logic [31:0] addr, logic iv,
                              logic [31:0] ins, logic [31:0] ipc);
    obs_t o;
    o = '{req_valid: v, req_addr: addr, inst_valid: iv, inst: ins, inst_pc: ipc};
    return o;
  endfunction

  function automatic obs_t obs_a();
    return ob(a_req_valid, a_req_addr, a_inst_valid, a_inst, a_inst_pc);
  endfunction

  function automatic obs_t obs_b();
    return ob(b_req_valid, b_req_addr, b_inst_valid, b_inst, b_inst_pc);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_obs(string tag, obs_t act, obs_t exp);
    check({tag, ".req_valid"},  32'(act.req_valid),  32'(exp.req_valid));
    check({tag, ".req_addr"},   act.req_addr,        exp.req_addr);
    check({tag, ".inst_valid"}, 32'(act.inst_valid), 32'(exp.inst_valid));
    check({tag, ".inst"},       act.inst,            exp.inst);
    check({tag, ".inst_pc"},    act.inst_pc,         exp.inst_pc);
  endtask

  // Drive one cycle of stimulus, advance both models, sample 1ns after the edge.
  task automatic tick(stim_t s);
    rst         = s.rst;
    trap_valid  = s.trap_valid;
    trap_pc     = s.trap_pc;
    redir_valid = s.redir_valid;
    redir_pc    = s.redir_pc;
    req_ready   = s.req_ready;
    rsp_valid   = s.rsp_valid;
    rsp_data    = s.rsp_data;
    inst_ready  = s.inst_ready;
    @(posedge clk);
    ma = m_step(ma, s, RV_A);
    mb = m_step(mb, s, RV_B);
    #1;
  endtask

  stim_t idle_s;

  initial begin
    idle_s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ma = '0;
    mb = '0;

    // Directed table: one row per cycle, expected dut_a outputs after the edge.
    vecs.push_back('{mk(1,0,0,0,0,0,0,0,0),                         ob(0,32'h80000000,0,32'h0,32'h0)});
    vecs.push_back('{mk(0,0,0,0,0,0,0,0,0),                         ob(1,32'h80000000,0,32'h0,32'h0)});
    vecs.push_back('{mk(0,0,0,0,0,1,0,0,0),                         ob(0,32'h80000000,0,32'h0,32'h0)});
    vecs.push_back('{mk(0,0,0,0,0,0,1,32'h00000413,0),              ob(0,32'h80000004,1,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,0,0,0,0,0,0,0,0),                         ob(0,32'h80000004,1,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,0,0,0,0,1,1,32'hDEADBEEF,0),              ob(0,32'h80000004,1,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,0,0,0,0,0,0,0,0),                         ob(0,32'h80000004,1,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,0,0,0,0,0,0,0,0),                         ob(0,32'h80000004,1,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,0,0,0,0,0,0,0,0),                         ob(0,32'h80000004,1,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,0,0,0,0,0,0,0,1),                         ob(1,32'h80000004,0,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,0,0,0,0,1,0,0,0),                         ob(0,32'h80000004,0,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,0,0,1,32'h80000100,0,0,0,0),              ob(0,32'h80000100,0,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,0,0,0,0,0,1,32'h11111111,0),              ob(1,32'h80000100,0,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,1,32'h80000200,1,32'h80000300,0,0,0,0),   ob(1,32'h80000200,0,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,0,0,0,0,1,0,0,0),                         ob(0,32'h80000200,0,32'h00000413,32'h80000000)});
    vecs.push_back('{mk(0,0,0,0,0,0,1,32'h00100073,0),              ob(0,32'h80000204,1,32'h00100073,32'h80000200)});
    vecs.push_back('{mk(0,0,0,1,32'h80000400,0,0,0,1),              ob(1,32'h80000400,0,32'h00100073,32'h80000200)});
    vecs.push_back('{mk(0,0,0,1,32'h80000500,1,0,0,0),              ob(0,32'h80000500,0,32'h00100073,32'h80000200)});
    vecs.push_back('{mk(0,0,0,0,0,0,1,32'h00000022,0),              ob(1,32'h80000500,0,32'h00100073,32'h80000200)});
    vecs.push_back('{mk(0,0,0,0,0,1,0,0,0),                         ob(0,32'h80000500,0,32'h00100073,32'h80000200)});
    vecs.push_back('{mk(0,1,32'h80000600,0,0,0,1,32'h00000033,0),   ob(1,32'h80000600,0,32'h00100073,32'h80000200)});

    foreach (vecs[i]) begin
      tick(vecs[i].s);
      check_obs($sformatf("vec%0d", i), obs_a(), vecs[i].e);
    end

    // Wrap of the sequential PC, then reset in the middle of a transaction.
    tick(mk(1,0,0,0,0,0,0,0,0));
    tick(idle_s);
    tick(mk(0,0,0,0,0,1,0,0,0));
    tick(mk(0,0,0,0,0,0,1,32'h00000513,0));
    check("wrap.inst_pc",    b_inst_pc,  RV_B);
    check("wrap.pc",         b_req_addr, 32'h0);
    tick(mk(0,0,0,0,0,0,0,0,1));
    check("wrap.req_valid",  32'(b_req_valid), 32'd1);
    check("wrap.req_addr",   b_req_addr, 32'h0);
    tick(mk(0,0,0,0,0,1,0,0,0));
    check("wrap.wait",       32'(b_req_valid), 32'd0);
    tick(mk(1,0,0,0,0,0,1,32'h12345678,0));
    check_obs("rst_mid", obs_a(), ob(0, RV_A, 0, 32'h0, 32'h0));
    tick(mk(0,0,0,0,0,0,1,32'hCAFEF00D,0));
    check_obs("late_rsp_a", obs_a(), ob(1, RV_A, 0, 32'h0, 32'h0));
    check_obs("late_rsp_b", obs_b(), ob(1, RV_B, 0, 32'h0, 32'h0));

    // Randomized traffic scored against the transaction model.
    tick(mk(1,0,0,0,0,0,0,0,0));
    for (int c = 0; c < 3000; c++) begin
      stim_t s;
      s.rst         = ($urandom_range(0, 149) == 0);
      s.trap_valid  = ($urandom_range(0, 19) == 0);
      s.trap_pc     = $urandom;
      s.redir_valid = ($urandom_range(0, 11) == 0);
      s.redir_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      s.req_ready   = ($urandom_range(0, 1) == 1);
      s.rsp_valid   = ($urandom_range(0, 4) < 2);
      s.rsp_data    = $urandom;
      s.inst_ready  = ($urandom_range(0, 1) == 1);
      tick(s);
      check_obs($sformatf("rnd%0d.a", c), obs_a(), m_obs(ma));
      check_obs($sformatf("rnd%0d.b", c), obs_b(), m_obs(mb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
